// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared pipeline widths and the fetch entry type
package pipeline_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC = '0;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: fetch-side and decode-side handshake of the fetch queue
interface fetch_queue_if #(
    parameter int XLEN  = pipeline_pkg::XLEN,
    parameter int DEPTH = 4
);

    logic                         in_valid;
    logic [XLEN-1:0]              in_pc;
    logic [XLEN-1:0]              in_instr;
    logic                         stall_out;
    logic                         flush;
    logic                         out_valid;
    logic                         out_ready;
    logic [XLEN-1:0]              out_pc;
    logic [XLEN-1:0]              out_instr;
    logic                         out_misaligned;
    logic [$clog2(DEPTH+1)-1:0]   count;

    modport master (
        output in_valid, in_pc, in_instr, flush, out_ready,
        input  stall_out, out_valid, out_pc, out_instr, out_misaligned, count
    );

    modport slave (
        input  in_valid, in_pc, in_instr, flush, out_ready,
        output stall_out, out_valid, out_pc, out_instr, out_misaligned, count
    );

endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: first-word-fall-through FIFO between fetch and decode with flush
module fetch_queue
    import pipeline_pkg::*;
#(
    parameter int XLEN  = pipeline_pkg::XLEN,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_queue_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    fetch_entry_t  r_mem [DEPTH];

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    fetch_entry_t  w_head;

    // Handshake qualifiers and head outputs; everything depends on registered
    // count, so stall_out has no combinational path from the inputs.
    always_comb begin
        w_full             = (r_count == CW'(DEPTH));
        w_empty            = (r_count == '0);
        w_push             = bus.in_valid && !w_full && !bus.flush;
        w_pop              = !w_empty && bus.out_ready && !bus.flush;
        w_head             = r_mem[r_rd_ptr];
        bus.stall_out      = w_full;
        bus.out_valid      = !w_empty;
        bus.out_pc         = w_empty ? {XLEN{1'b0}} : w_head.pc;
        bus.out_instr      = w_empty ? {XLEN{1'b0}} : w_head.instr;
        bus.out_misaligned = !w_empty && (w_head.pc[1:0] != 2'b00);
        bus.count          = r_count;
    end

    // Pointers and occupancy; flush redirects to an empty queue and wins over push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (bus.flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= w_push ? r_wr_ptr + AW'(1) : r_wr_ptr;
            r_rd_ptr <= w_pop  ? r_rd_ptr + AW'(1) : r_rd_ptr;
            r_count  <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Entry storage is unreset; outputs are gated by empty so stale data never leaks.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= '{pc: bus.in_pc, instr: bus.in_instr};
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed self-checking bench for fetch_queue
module tb_fetch_queue;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    fetch_queue_if #(.XLEN(32), .DEPTH(4)) bus ();

    fetch_queue #(.XLEN(32), .DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr, input logic rdy, input logic fl);
        bus.in_valid  = v;
        bus.in_pc     = pc;
        bus.in_instr  = instr;
        bus.out_ready = rdy;
        bus.flush     = fl;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic do_flush();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        tick();
        idle();
    endtask

    initial begin
        idle();
        tick();
        tick();
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_stall", 32'(bus.stall_out), 32'd0);
        check("rst_pc", bus.out_pc, 32'h0);
        check("rst_instr", bus.out_instr, 32'h0);
        check("rst_mis", 32'(bus.out_misaligned), 32'd0);
        rst_n = 1'b1;
        tick();

        drive(1'b1, 32'h0, 32'h00000013, 1'b0, 1'b0);
        tick();
        check("lat1_valid", 32'(bus.out_valid), 32'd1);
        check("lat1_pc", bus.out_pc, 32'h0);
        drive(1'b1, 32'h4, 32'h00100093, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h8, 32'h00200113, 1'b0, 1'b0);
        tick();
        idle();
        check("p3_count", 32'(bus.count), 32'd3);
        check("p3_pc", bus.out_pc, 32'h0);
        check("p3_instr", bus.out_instr, 32'h00000013);
        check("p3_stall", 32'(bus.stall_out), 32'd0);
        do_flush();

        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(4 * i), 32'h1000 + 32'(i), 1'b0, 1'b0);
            tick();
        end
        check("full_count", 32'(bus.count), 32'd4);
        check("full_stall", 32'(bus.stall_out), 32'd1);
        drive(1'b1, 32'h10, 32'h1010, 1'b0, 1'b0);
        tick();
        tick();
        check("full_hold_count", 32'(bus.count), 32'd4);
        check("full_hold_stall", 32'(bus.stall_out), 32'd1);
        drive(1'b1, 32'h10, 32'h1010, 1'b1, 1'b0);
        tick();
        idle();
        check("popfull_count", 32'(bus.count), 32'd3);
        check("popfull_stall", 32'(bus.stall_out), 32'd0);
        check("popfull_pc", bus.out_pc, 32'h4);
        bus.out_ready = 1'b1;
        check("drain_pc4", bus.out_pc, 32'h4);
        check("drain_in4", bus.out_instr, 32'h1001);
        tick();
        check("drain_pc8", bus.out_pc, 32'h8);
        tick();
        check("drain_pcC", bus.out_pc, 32'hC);
        tick();
        check("drain_empty", 32'(bus.out_valid), 32'd0);
        check("drain_count", 32'(bus.count), 32'd0);
        idle();

        drive(1'b1, 32'h0, 32'h2000, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h4, 32'h2004, 1'b0, 1'b0);
        tick();
        for (int i = 2; i < 12; i++) begin
            drive(1'b1, 32'(4 * i), 32'h2000 + 32'(4 * i), 1'b1, 1'b0);
            check("pp_pc", bus.out_pc, 32'(4 * (i - 2)));
            check("pp_instr", bus.out_instr, 32'h2000 + 32'(4 * (i - 2)));
            tick();
            check("pp_count", 32'(bus.count), 32'd2);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check("pp_tail0", bus.out_pc, 32'h28);
        tick();
        check("pp_tail1", bus.out_pc, 32'h2C);
        tick();
        check("pp_empty", 32'(bus.out_valid), 32'd0);
        idle();

        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h20 + 32'(4 * i), 32'h3000, 1'b0, 1'b0);
            tick();
        end
        check("fl_pre_count", 32'(bus.count), 32'd3);
        drive(1'b1, 32'h40, 32'h3040, 1'b1, 1'b1);
        tick();
        idle();
        check("fl_count", 32'(bus.count), 32'd0);
        check("fl_valid", 32'(bus.out_valid), 32'd0);
        check("fl_pc", bus.out_pc, 32'h0);
        drive(1'b1, 32'h100, 32'h3100, 1'b0, 1'b0);
        tick();
        idle();
        check("fl_tgt_pc", bus.out_pc, 32'h100);
        check("fl_tgt_count", 32'(bus.count), 32'd1);
        do_flush();
        check("fl_empty_count", 32'(bus.count), 32'd0);

        drive(1'b1, 32'h100, 32'h4100, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h104, 32'h4104, 1'b0, 1'b0);
        tick();
        idle();
        check("ar_pre_count", 32'(bus.count), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid", 32'(bus.out_valid), 32'd0);
        check("ar_count", 32'(bus.count), 32'd0);
        check("ar_stall", 32'(bus.stall_out), 32'd0);
        #1;
        rst_n = 1'b1;
        tick();
        drive(1'b1, 32'h0, 32'h4000, 1'b0, 1'b0);
        tick();
        idle();
        check("ar_post_pc", bus.out_pc, 32'h0);
        check("ar_post_instr", bus.out_instr, 32'h4000);
        check("ar_post_count", 32'(bus.count), 32'd1);
        do_flush();

        drive(1'b1, 32'h6, 32'h5006, 1'b0, 1'b0);
        tick();
        check("mis_pc", bus.out_pc, 32'h6);
        check("mis_set", 32'(bus.out_misaligned), 32'd1);
        drive(1'b1, 32'h8, 32'h5008, 1'b1, 1'b0);
        tick();
        idle();
        check("mis_next_pc", bus.out_pc, 32'h8);
        check("mis_clr", 32'(bus.out_misaligned), 32'd0);
        check("mis_count", 32'(bus.count), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
